// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite register file slave with a live display mirror of one register.
// Defining AXIL_REGFILE_WSTRB_EN adds the s_wstrb input for per-byte-lane write enables.
module axil_regfile_slave #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int DISP_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
`ifdef AXIL_REGFILE_WSTRB_EN
    input  logic [DATA_W/8-1:0] s_wstrb,
`endif
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic [DATA_W-1:0] disp_out
);
    logic              en, aw_held, w_held;
    logic              aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [ADDR_W-1:0] aw_addr, wr_addr;
    logic [DATA_W-1:0] w_data, wr_data, wr_mask, rd_mux;
    logic [DATA_W-1:0] regs [NUM_REGS];

    assign s_awready = en & ~aw_held & ~s_bvalid;
    assign s_wready  = en & ~w_held & ~s_bvalid;
    assign s_arready = en & ~s_rvalid;
    assign aw_hs     = s_awvalid & s_awready;
    assign w_hs      = s_wvalid & s_wready;
    assign ar_hs     = s_arvalid & s_arready;
    // The write commits on whichever edge completes the second of AW and W.
    assign commit    = (aw_hs | aw_held) & (w_hs | w_held);
    assign wr_addr   = aw_hs ? s_awaddr : aw_addr;
    assign wr_data   = w_hs ? s_wdata : w_data;
    assign wr_ok     = 32'(wr_addr) < NUM_REGS;
    assign rd_ok     = 32'(s_araddr) < NUM_REGS;
    assign disp_out  = regs[DISP_REG];

`ifdef AXIL_REGFILE_WSTRB_EN
    logic [DATA_W/8-1:0] w_strb, wr_strb;
    assign wr_strb = w_hs ? s_wstrb : w_strb;
    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < DATA_W; b++) wr_mask[b] = wr_strb[b/8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_strb <= '0;
        else if (w_hs) w_strb <= s_wstrb;
    end
`else
    assign wr_mask = '1;
`endif

    // Out-of-range read addresses match no register and fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (s_araddr == ADDR_W'(i)) rd_mux = regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (commit && wr_addr == ADDR_W'(i))
                    regs[i] <= (regs[i] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= 2'b00;
        end else begin
            en      <= 1'b1;
            aw_held <= commit ? 1'b0 : (aw_held | aw_hs);
            w_held  <= commit ? 1'b0 : (w_held | w_hs);
            if (aw_hs) aw_addr <= s_awaddr;
            if (w_hs) w_data <= s_wdata;
            if (commit) begin
                s_bvalid <= 1'b1;
                s_bresp  <= wr_ok ? 2'b00 : 2'b10;
            end else if (s_bready) begin
                s_bvalid <= 1'b0;
            end
            if (ar_hs) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_mux;
                s_rresp  <= rd_ok ? 2'b00 : 2'b10;
            end else if (s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: scenario tasks with a response scoreboard for axil_regfile_slave.
// Built with NUM_REGS=12 so the out-of-range response path is reachable at ADDR_W=4.
module tb_axil_regfile_slave;
    localparam int NR = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
    logic [3:0] s_awaddr = '0, s_araddr = '0;
    logic [7:0] s_wdata = '0;
    logic       s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0] s_bresp, s_rresp;
    logic [7:0] s_rdata, disp_out;

    int         pass = 0, total = 0;
    logic [7:0] model [16];
    logic [1:0] bq [$];
    logic [9:0] rq [$];

    axil_regfile_slave #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(NR), .DISP_REG(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .disp_out(disp_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_write(input logic [3:0] a, input logic [7:0] d);
        if (a < NR) begin
            model[a] = d;
            bq.push_back(2'b00);
        end else bq.push_back(2'b10);
    endtask

    task automatic push_read(input logic [3:0] a);
        rq.push_back(a < NR ? {2'b00, model[a]} : {2'b10, 8'h00});
    endtask

    // Drives the selected valids together from a negedge; each drops after its own handshake.
    task automatic send(input bit aw, input bit w, input bit ar, input logic [3:0] wa,
                        input logic [7:0] d, input logic [3:0] ra, output bit ok);
        bit a, wh, r;
        s_awvalid = aw; s_awaddr = wa; s_wvalid = w; s_wdata = d; s_arvalid = ar; s_araddr = ra;
        for (int n = 0; n < 20 && (s_awvalid || s_wvalid || s_arvalid); n++) begin
            a = s_awvalid && s_awready;
            wh = s_wvalid && s_wready;
            r = s_arvalid && s_arready;
            @(negedge clk);
            if (a) s_awvalid = 1'b0;
            if (wh) s_wvalid = 1'b0;
            if (r) s_arvalid = 1'b0;
        end
        ok = !(s_awvalid || s_wvalid || s_arvalid);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp, output bit ok);
        ok = 1'b0; resp = 'x; s_bready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (s_bvalid) begin
                resp = s_bresp; ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_bready = 1'b0;
    endtask

    task automatic get_r(output logic [9:0] got, output bit ok);
        ok = 1'b0; got = 'x; s_rready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (s_rvalid) begin
                got = {s_rresp, s_rdata}; ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_rready = 1'b0;
    endtask

    task automatic test_reset;
        logic [9:0] act;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        act = {s_bvalid, s_rvalid, s_awready, s_wready, s_arready, s_bresp, s_rresp, 1'b0};
        total++;
        if (act !== 10'h0 || s_rdata !== 8'h00 || disp_out !== 8'h00)
            $display("FAIL reset_outputs: flags=%h rdata=%h disp=%h, required all 0", act, s_rdata, disp_out);
        else pass++;
        rst_n = 1'b1;
        #1;
        total++;
        if ({s_awready, s_wready, s_arready} !== 3'b000)
            $display("FAIL reset_ready_early: ready=%b, required 000", {s_awready, s_wready, s_arready});
        else pass++;
        @(posedge clk); #1;
        total++;
        if ({s_awready, s_wready, s_arready} !== 3'b111)
            $display("FAIL reset_ready_after: ready=%b, required 111", {s_awready, s_wready, s_arready});
        else pass++;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        bit ok, okr;
        logic [1:0] br, eb;
        logic [9:0] got, er;
        push_write(4'd3, 8'hA5);
        send(1, 1, 0, 4'd3, 8'hA5, 4'd0, ok);
        total++;
        if (!ok || s_bvalid !== 1'b1)
            $display("FAIL same_edge_bvalid: ok=%0d bvalid=%b, required 1", ok, s_bvalid);
        else pass++;
        get_b(br, okr);
        eb = bq.pop_front();
        total++;
        if (!okr || br !== eb) $display("FAIL same_edge_bresp: got %b, required %b", br, eb);
        else pass++;
        push_read(4'd3);
        send(0, 0, 1, 4'd0, 8'h00, 4'd3, ok);
        get_r(got, okr);
        er = rq.pop_front();
        total++;
        if (!ok || !okr || got !== er) $display("FAIL read_back3: got %h, required %h", got, er);
        else pass++;
    endtask

    task automatic test_split_write;
        bit ok, okr;
        logic [1:0] br, eb;
        push_write(4'd0, 8'h3C);
        send(0, 1, 0, 4'd0, 8'h3C, 4'd0, ok);
        s_wdata = 8'hFF;
        total++;
        if (!ok || {s_wready, s_awready, s_bvalid} !== 3'b010)
            $display("FAIL w_first_held: w/aw/b=%b, required 010", {s_wready, s_awready, s_bvalid});
        else pass++;
        repeat (2) @(negedge clk);
        send(1, 0, 0, 4'd0, 8'hFF, 4'd0, ok);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (!ok || {s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000)
                $display("FAIL b_hold%0d: bvalid/bresp/aw/w=%b, required 10000", n,
                         {s_bvalid, s_bresp, s_awready, s_wready});
            else pass++;
            @(negedge clk);
        end
        get_b(br, okr);
        eb = bq.pop_front();
        total++;
        if (!okr || br !== eb) $display("FAIL split_bresp: got %b, required %b", br, eb);
        else pass++;
        total++;
        if (disp_out !== model[0]) $display("FAIL disp_out: got %h, required %h", disp_out, model[0]);
        else pass++;
    endtask

    task automatic test_range;
        bit ok, okr;
        logic [1:0] br, eb;
        logic [9:0] got, er;
        logic [3:0] wa [4] = '{4'd2, 4'd11, 4'd12, 4'd14};
        logic [3:0] ra [5] = '{4'd14, 4'd12, 4'd11, 4'd2, 4'd15};
        for (int i = 0; i < 4; i++) begin
            push_write(wa[i], 8'h50 + 8'(i));
            send(1, 1, 0, wa[i], 8'h50 + 8'(i), 4'd0, ok);
            get_b(br, okr);
            eb = bq.pop_front();
            total++;
            if (!ok || !okr || br !== eb) $display("FAIL range_bresp_a%0d: got %b, required %b", wa[i], br, eb);
            else pass++;
        end
        for (int i = 0; i < 5; i++) begin
            push_read(ra[i]);
            send(0, 0, 1, 4'd0, 8'h00, ra[i], ok);
            get_r(got, okr);
            er = rq.pop_front();
            total++;
            if (!ok || !okr || got !== er) $display("FAIL range_read_a%0d: got %h, required %h", ra[i], got, er);
            else pass++;
        end
    endtask

    task automatic test_collision;
        bit ok, okr;
        logic [1:0] br, eb;
        logic [9:0] got, er;
        push_write(4'd5, 8'h11);
        send(1, 1, 0, 4'd5, 8'h11, 4'd0, ok);
        get_b(br, okr);
        void'(bq.pop_front());
        push_read(4'd5);
        push_write(4'd5, 8'h22);
        send(1, 1, 1, 4'd5, 8'h22, 4'd5, ok);
        get_b(br, okr);
        eb = bq.pop_front();
        total++;
        if (!ok || !okr || br !== eb) $display("FAIL collide_bresp: got %b, required %b", br, eb);
        else pass++;
        get_r(got, okr);
        er = rq.pop_front();
        total++;
        if (!okr || got !== er) $display("FAIL collide_read_old: got %h, required %h", got, er);
        else pass++;
        push_read(4'd5);
        send(0, 0, 1, 4'd0, 8'h00, 4'd5, ok);
        get_r(got, okr);
        er = rq.pop_front();
        total++;
        if (!ok || !okr || got !== er) $display("FAIL collide_reread: got %h, required %h", got, er);
        else pass++;
    endtask

    task automatic test_back_to_back;
        bit ok, okr;
        logic [1:0] br, eb;
        logic [9:0] got, er;
        logic [3:0] a;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            push_write(a, d);
            send(1, 1, 0, a, d, 4'd0, ok);
            get_b(br, okr);
            eb = bq.pop_front();
            total++;
            if (!ok || !okr || br !== eb) $display("FAIL b2b_bresp%0d: got %b, required %b", i, br, eb);
            else pass++;
        end
        for (int i = 0; i < 16; i++) begin
            push_read(4'(i));
            send(0, 0, 1, 4'd0, 8'h00, 4'(i), ok);
            get_r(got, okr);
            er = rq.pop_front();
            total++;
            if (!ok || !okr || got !== er) $display("FAIL b2b_read_a%0d: got %h, required %h", i, got, er);
            else pass++;
        end
        total++;
        if (disp_out !== model[0]) $display("FAIL b2b_disp: got %h, required %h", disp_out, model[0]);
        else pass++;
    endtask

    task automatic test_reset_mid;
        bit ok, okr, seen;
        logic [9:0] got, er;
        push_write(4'd0, 8'h9E);
        send(1, 1, 0, 4'd0, 8'h9E, 4'd0, ok);
        push_read(4'd0);
        send(0, 0, 1, 4'd0, 8'h00, 4'd0, ok);
        total++;
        if ({s_bvalid, s_rvalid} !== 2'b11)
            $display("FAIL mid_pending: bvalid/rvalid=%b, required 11", {s_bvalid, s_rvalid});
        else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready, s_bresp, s_rresp} !== 9'h0 ||
            s_rdata !== 8'h00 || disp_out !== 8'h00)
            $display("FAIL mid_reset_async: flags=%b rdata=%h disp=%h, required all 0",
                     {s_bvalid, s_rvalid, s_awready, s_wready, s_arready, s_bresp, s_rresp}, s_rdata, disp_out);
        else pass++;
        bq.delete(); rq.delete();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_bready = 1'b1; s_rready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (s_bvalid || s_rvalid) seen = 1'b1;
        end
        s_bready = 1'b0; s_rready = 1'b0;
        total++;
        if (seen) $display("FAIL mid_no_response: stale response seen=%0d, required 0", seen);
        else pass++;
        push_read(4'd0);
        send(0, 0, 1, 4'd0, 8'h00, 4'd0, ok);
        get_r(got, okr);
        er = rq.pop_front();
        total++;
        if (!ok || !okr || got !== er) $display("FAIL mid_reg_cleared: got %h, required %h", got, er);
        else pass++;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_split_write;
        test_range;
        test_collision;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/axil_regfile_slave.md
AXIL_REGFILE_SLAVE -- requirements
Module: axil_regfile_slave

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 Parameter `DATA_W`, default 8: register and data bus width, range 4..32.
REQ-003 Parameter `ADDR_W`, default 4: address width, range 2..8.
REQ-004 Parameter `NUM_REGS`, default 16: number of implemented registers; SHALL be 1..2^ADDR_W.
REQ-005 Parameter `DISP_REG`, default 0: index of the register mirrored on `disp_out`; SHALL be less than NUM_REGS.
REQ-006 Ports, in this order (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst_n` in 1: async reset, active low.
- `s_awvalid` in 1 / `s_awready` out 1 / `s_awaddr` in ADDR_W: write address channel.
- `s_wvalid` in 1 / `s_wready` out 1 / `s_wdata` in DATA_W: write data channel.
- `s_bvalid` out 1 / `s_bready` in 1 / `s_bresp` out 2: write response channel.
- `s_arvalid` in 1 / `s_arready` out 1 / `s_araddr` in ADDR_W: read address channel.
- `s_rvalid` out 1 / `s_rready` in 1 / `s_rdata` out DATA_W / `s_rresp` out 2: read data channel.
- `disp_out` out DATA_W: live contents of register DISP_REG, for the hex display.

Function
REQ-007 A handshake SHALL occur on a rising edge where valid and ready are both 1; once a valid is asserted, the block SHALL tolerate the manager holding it high.
REQ-008 The write address (AW) and write data (W) handshakes SHALL be accepted independently, in either order or on the same edge. Each is held in its own flag/register.
REQ-009 `s_awready` SHALL be `en & !aw_held & !s_bvalid`. `s_wready` SHALL be `en & !w_held & !s_bvalid`. Here `en` is a flop that is 0 in reset and sets to 1 on the first edge after reset is released.
REQ-010 On the edge where the second of AW/W completes, the write SHALL commit and `s_bvalid` SHALL go to 1. Both held flags SHALL clear on that same edge.
REQ-011 Write response rules:
- `s_bresp` SHALL be 2'b00 if the address is below NUM_REGS.
- Otherwise `s_bresp` SHALL be 2'b10 (SLVERR), and no register changes.
REQ-012 `s_bvalid` SHALL stay at 1, with `s_bresp` stable, until the first edge with `s_bready`=1.
REQ-013 `s_arready` SHALL be `en & !s_rvalid`.
REQ-014 On an AR handshake, `s_rdata` and `s_rresp` SHALL be registered on the same edge and `s_rvalid` SHALL go to 1 (one-cycle latency).
- Out-of-range address: `s_rdata`=0 and `s_rresp`=2'b10.
- They SHALL hold stable until the `s_rready` handshake.
REQ-015 If a read and a write commit to the same register on the same edge, the read SHALL return the pre-write value.
REQ-016 The read and write paths SHALL be fully independent; neither SHALL stall the other.
REQ-017 `disp_out` SHALL be combinational from register DISP_REG and SHALL reflect a write from the cycle after the commit.
REQ-018 Address bits are used unmodified; there SHALL be no aliasing or wrap of out-of-range addresses.

Reset
REQ-019 Asserting `rst_n`=0 SHALL immediately force the following, even mid-transaction:
- all registers to 0;
- aw_held, w_held and `en` to 0;
- `s_bvalid` and `s_rvalid` to 0, with `s_bresp`, `s_rresp` and `s_rdata` at 0;
- all ready outputs to 0.
REQ-020 Transactions in flight when reset is asserted SHALL be discarded and produce no response.

Configuration
REQ-021 Macro `AXIL_REGFILE_WSTRB_EN`:
- Defined: add input `s_wstrb`, width DATA_W/8, captured together with W. A byte lane SHALL be written only if its strobe bit is 1. DATA_W SHALL be a multiple of 8.
- Undefined: the port is absent and every write updates all DATA_W bits.

Verification
REQ-022 The bench SHALL cover these directed scenarios (default parameters):
- Reset: outputs 0; `s_arready`/`s_awready`/`s_wready` become 1 one edge after `rst_n` rises.
- AW addr 3 and W 0xA5 on the same edge: `s_bvalid`=1 with bresp 00; a later read of addr 3 returns 0xA5 with rresp 00.
- W 0x3C first, AW addr 0 three cycles later, `s_bready` held 0 for 4 cycles: bvalid holds, awready/wready stay 0, then `disp_out`=0x3C.
- NUM_REGS=12, write addr 14: bresp 10 and no change; read addr 14: rdata 0, rresp 10.
- Addr 5 holds 0x11; read 5 and write 0x22 to 5 commit on the same edge: rdata 0x11, then a re-read gives 0x22.
- `rst_n` pulled low while bvalid=1 and rvalid=1: both drop immediately and no response appears after release.
